// File: rtl/opcodes.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : opcodes                                                        |
// | Purpose   : Shared instruction/register types plus fetch FSM and fault     |
// |             encodings used by fetch_unit and its neighbours.               |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package opcodes;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] register_t;
  typedef logic [31:0]     instruction_t;

  typedef enum logic [2:0] {
    FETCH = 3'd0,
    WAIT  = 3'd1,
    ISSUE = 3'd2,
    EXEC  = 3'd3,
    HALT  = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISALIGN = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } fault_cause_t;

  function automatic logic is_aligned(input register_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Interface : fetch_unit_if                                                  |
// | Purpose   : PC input, instruction-memory handshake and retire/fault        |
// |             outputs of the fetch sequencer.                                |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
interface fetch_unit_if;
  import opcodes::*;

  register_t    pc;
  logic         bcu_enable;
  logic         imem_req;
  register_t    imem_addr;
  logic         imem_gnt;
  logic         imem_rvalid;
  instruction_t imem_rdata;
  instruction_t instr;
  logic         instr_valid;
  logic         exec_ready;
  logic         fetch_fault;
  fault_cause_t fault_cause;
  register_t    fault_pc;
  logic [31:0]  instr_count;

  modport master (
    input  pc, imem_gnt, imem_rvalid, imem_rdata, exec_ready,
    output bcu_enable, imem_req, imem_addr, instr, instr_valid,
           fetch_fault, fault_cause, fault_pc, instr_count
  );

  modport slave (
    output pc, imem_gnt, imem_rvalid, imem_rdata, exec_ready,
    input  bcu_enable, imem_req, imem_addr, instr, instr_valid,
           fetch_fault, fault_cause, fault_pc, instr_count
  );

endinterface
`default_nettype wire

// File: rtl/fetch_watchdog.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_watchdog                                                 |
// | Purpose   : Counts WAIT cycles without read data; flags the limit cycle.   |
// |             Only built when FETCH_TIMEOUT_EN is defined.                   |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
`ifdef FETCH_TIMEOUT_EN
module fetch_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic hit,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  // Outside WAIT the count is held at zero, so every WAIT entry starts fresh.
  always_comb begin
    count_d = '0;
    if (run && !hit) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Fires on the TIMEOUT-th WAIT cycle; the caller lets rvalid take priority.
  assign expired = run && (count_q == CW'(TIMEOUT - 1));

endmodule
`endif
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : fetch_unit                                                     |
// | Purpose   : Fetch/issue/retire sequencer closing the loop with branch_unit.|
// |             Optional WAIT watchdog enabled by macro FETCH_TIMEOUT_EN.      |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module fetch_unit
  import opcodes::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);

  fetch_state_t state_q, state_d;
  instruction_t instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         fault_q, fault_d;
  fault_cause_t cause_q, cause_d;
  register_t    fault_pc_q, fault_pc_d;
  logic [31:0]  count_q, count_d;
  logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  fetch_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state_q == WAIT),
    .hit     (bus.imem_rvalid),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;
    cause_d       = cause_q;
    fault_pc_d    = fault_pc_q;
    count_d       = count_q;
    case (state_q)
      FETCH: begin
        if (!is_aligned(bus.pc)) begin
          fault_d    = 1'b1;
          cause_d    = CAUSE_MISALIGN;
          fault_pc_d = bus.pc;
          state_d    = HALT;
        end else if (bus.imem_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Data arriving on the limit cycle still counts as a good fetch.
        if (bus.imem_rvalid) begin
          instr_d       = bus.imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = ISSUE;
        end else if (timeout_hit) begin
          fault_d    = 1'b1;
          cause_d    = CAUSE_TIMEOUT;
          fault_pc_d = bus.pc;
          state_d    = HALT;
        end
      end
      ISSUE: begin
        if (bus.exec_ready) begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        count_d       = count_q + 32'd1;
        instr_valid_d = 1'b0;
        state_d       = FETCH;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= FETCH;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      cause_q       <= CAUSE_NONE;
      fault_pc_q    <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
      cause_q       <= cause_d;
      fault_pc_q    <= fault_pc_d;
      count_q       <= count_d;
    end
  end

  // Request is gated by rst so nothing is issued while reset is held.
  assign bus.imem_req    = rst && (state_q == FETCH) && is_aligned(bus.pc);
  assign bus.imem_addr   = bus.pc;
  assign bus.bcu_enable  = (state_q == EXEC);
  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.fetch_fault = fault_q;
  assign bus.fault_cause = cause_q;
  assign bus.fault_pc    = fault_pc_q;
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_fetch_unit                                                  |
// | Purpose   : Self-checking bench: PC/memory model with address and          |
// |             instruction scoreboards, misalign table, reset and timeout.    |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module tb_fetch_unit;
  import opcodes::*;

  localparam int unsigned TB_TIMEOUT = 16;
  localparam instruction_t NOP = 32'h00000033;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_unit_if bus ();

  fetch_unit #(
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  register_t    pc_m, ret_addr, last_hs_addr, addr_prev;
  bit           auto_mem, jal_at8, hs_prev, rv_withhold, period_check;
  int           gnt_stall, ready_stall, retired, cyc_no, last_retire_cyc, hs_count;
  register_t    exp_addr_q[$];
  instruction_t exp_instr_q[$];

  typedef struct {
    register_t    pc;
    logic         exp_req;
    logic         exp_fault;
    fault_cause_t exp_cause;
    register_t    exp_fault_pc;
  } ma_vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic instruction_t jal_enc(input logic [20:0] off, input logic [4:0] rd);
    return {off[20], off[10:1], off[11], off[19:12], rd, 7'b1101111};
  endfunction

  function automatic logic [31:0] jal_off(input instruction_t w);
    return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
  endfunction

  function automatic instruction_t mem_word(input register_t a);
    if (jal_at8 && a == 32'h8) return jal_enc(21'h1FFF8, 5'd1);
    return NOP;
  endfunction

  // One clock: observe at negedge, model branch_unit and memory, drive next inputs.
  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    check("req_bcu_exclusive", {31'b0, bus.imem_req & bus.bcu_enable}, 32'h0);
    if (bus.bcu_enable) begin
      if (exp_instr_q.size() == 0) fail_now("retire_without_expected_instr");
      else check("retired_instr", bus.instr, exp_instr_q.pop_front());
      if (period_check && retired > 0) check("retire_period", cyc_no - last_retire_cyc, 4);
      last_retire_cyc = cyc_no;
      retired++;
      if (bus.instr[6:0] == 7'b1101111) begin
        ret_addr = pc_m + 32'd4;
        pc_m     = pc_m + jal_off(bus.instr);
      end else begin
        pc_m = pc_m + 32'd4;
      end
      bus.pc = pc_m;
      exp_addr_q.push_back(pc_m);
    end
    if (auto_mem) begin
      if (hs_prev && !rv_withhold) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(addr_prev);
        exp_instr_q.push_back(bus.imem_rdata);
      end else begin
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = '0;
      end
      bus.imem_gnt = (gnt_stall == 0);
      if (gnt_stall > 0) gnt_stall--;
      if (bus.instr_valid && ready_stall > 0) begin
        bus.exec_ready = 1'b0;
        ready_stall--;
      end else begin
        bus.exec_ready = 1'b1;
      end
    end
    #1;
    hs_prev   = bus.imem_req && bus.imem_gnt;
    addr_prev = bus.imem_addr;
    if (hs_prev) begin
      hs_count++;
      last_hs_addr = bus.imem_addr;
      if (exp_addr_q.size() == 0) fail_now("fetch_without_expected_addr");
      else check("fetch_addr", bus.imem_addr, exp_addr_q.pop_front());
    end
  endtask

  // Leaves rst low; caller releases it so the in-reset state can be checked.
  task automatic do_reset(input register_t start_pc);
    @(negedge clk);
    rst             = 1'b0;
    bus.pc          = start_pc;
    pc_m            = start_pc;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    bus.exec_ready  = 1'b1;
    hs_prev = 1'b0; gnt_stall = 0; ready_stall = 0; rv_withhold = 1'b0;
    retired = 0; period_check = 1'b0; hs_count = 0;
    exp_addr_q.delete();
    exp_instr_q.delete();
    exp_addr_q.push_back(start_pc);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_retire(input int n, input int budget, input string name);
    int k = 0;
    while (retired < n && k < budget) begin
      cyc();
      k++;
    end
    if (retired < n) begin
      checks++;
      errors++;
      $display("FAIL %s_budget: retired %0d required %0d", name, retired, n);
    end
  endtask

  task automatic wait_hs(input int budget, input string name);
    int k = 0;
    while (hs_count == 0 && k < budget) begin
      cyc();
      k++;
    end
    if (hs_count == 0) fail_now({name, "_no_grant"});
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit");
    $fatal(1, "time limit");
  end

  initial begin
    ma_vec_t vecs[5];
    int k;
    vecs[0] = '{32'h00000102, 1'b0, 1'b1, CAUSE_MISALIGN, 32'h00000102};
    vecs[1] = '{32'h00000101, 1'b0, 1'b1, CAUSE_MISALIGN, 32'h00000101};
    vecs[2] = '{32'h00000103, 1'b0, 1'b1, CAUSE_MISALIGN, 32'h00000103};
    vecs[3] = '{32'hFFFFFFFE, 1'b0, 1'b1, CAUSE_MISALIGN, 32'hFFFFFFFE};
    vecs[4] = '{32'h00000100, 1'b1, 1'b0, CAUSE_NONE,     32'h00000000};

    rst = 1'b0; auto_mem = 1'b0; jal_at8 = 1'b0; cyc_no = 0; ret_addr = '0;
    last_hs_addr = '0; last_retire_cyc = 0;

    // Reset values, then 10 sequential no-ops at 4 cycles each.
    auto_mem = 1'b1;
    do_reset(32'h0);
    #1 check("req_in_reset", {31'b0, bus.imem_req}, 32'h0);
    rst = 1'b1;
    #1;
    check("rst_instr",       bus.instr, 32'h0);
    check("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rst_bcu_enable",  {31'b0, bus.bcu_enable}, 32'h0);
    check("rst_fault",       {31'b0, bus.fetch_fault}, 32'h0);
    check("rst_cause",       {30'b0, bus.fault_cause}, 32'h0);
    check("rst_fault_pc",    bus.fault_pc, 32'h0);
    check("rst_count",       bus.instr_count, 32'h0);
    check("first_req",       {31'b0, bus.imem_req}, 32'h1);
    period_check = 1'b1;
    run_retire(10, 200, "seq");
    cyc();
    check("seq_count", bus.instr_count, 32'd10);
    check("seq_next_fetch", last_hs_addr, 32'h28);

    // JAL at 0x8 redirects to 0x20000.
    jal_at8 = 1'b1;
    do_reset(32'h0);
    rst = 1'b1;
    run_retire(4, 100, "jump");
    check("jump_target_fetch", last_hs_addr, 32'h00020000);
    check("jump_ret_addr", ret_addr, 32'h0000000C);
    jal_at8 = 1'b0;

    // Grant withheld 3 cycles, then exec_ready withheld 5 cycles.
    do_reset(32'h0);
    gnt_stall = 3;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("gnt_stall_req",  {31'b0, bus.imem_req}, 32'h1);
      check("gnt_stall_addr", bus.imem_addr, 32'h0);
    end
    ready_stall = 5;
    k = 0;
    do begin
      cyc();
      k++;
    end while (!bus.instr_valid && k < 20);
    if (!bus.instr_valid) fail_now("bp_no_capture");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cyc();
      check("bp_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
      check("bp_instr",       bus.instr, NOP);
      check("bp_bcu_enable",  {31'b0, bus.bcu_enable}, 32'h0);
    end
    run_retire(1, 10, "bp");
    cyc();
    check("bp_count", bus.instr_count, 32'd1);

    // Misaligned PC table; the aligned row must keep requesting.
    auto_mem = 1'b0;
    foreach (vecs[v]) begin
      do_reset(vecs[v].pc);
      rst = 1'b1;
      #1 check("ma_first_req", {31'b0, bus.imem_req}, {31'b0, vecs[v].exp_req});
      cyc();
      check("ma_fault",    {31'b0, bus.fetch_fault}, {31'b0, vecs[v].exp_fault});
      check("ma_cause",    {30'b0, bus.fault_cause}, {30'b0, vecs[v].exp_cause});
      check("ma_fault_pc", bus.fault_pc, vecs[v].exp_fault_pc);
      for (int i = 0; i < 20; i++) begin
        cyc();
        check("ma_hold_req",   {31'b0, bus.imem_req}, {31'b0, vecs[v].exp_req});
        check("ma_hold_fault", {31'b0, bus.fetch_fault}, {31'b0, vecs[v].exp_fault});
      end
    end

    // Reset while in WAIT, then a stale response that must be dropped.
    auto_mem = 1'b1;
    do_reset(32'h0);
    rv_withhold = 1'b1;
    rst = 1'b1;
    wait_hs(10, "rw");
    cyc();
    auto_mem = 1'b0;
    rst = 1'b0;
    #1 check("rw_req_in_reset", {31'b0, bus.imem_req}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    bus.imem_gnt    = 1'b0;
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEADBEEF;
    #1;
    check("rw_fresh_req",   {31'b0, bus.imem_req}, 32'h1);
    check("rw_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rw_count",       bus.instr_count, 32'h0);
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    check("rw_late_instr",       bus.instr, 32'h0);
    check("rw_late_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
    check("rw_still_fetching",   {31'b0, bus.imem_req}, 32'h1);

`ifdef FETCH_TIMEOUT_EN
    // No data for 16 WAIT cycles: timeout fault.
    auto_mem = 1'b1;
    do_reset(32'h40);
    rv_withhold = 1'b1;
    rst = 1'b1;
    wait_hs(10, "to");
    for (int i = 1; i <= 16; i++) begin
      cyc();
      check("to_no_fault_yet", {31'b0, bus.fetch_fault}, 32'h0);
    end
    cyc();
    check("to_fault",    {31'b0, bus.fetch_fault}, 32'h1);
    check("to_cause",    {30'b0, bus.fault_cause}, 32'h2);
    check("to_fault_pc", bus.fault_pc, 32'h40);
    check("to_halt_req", {31'b0, bus.imem_req}, 32'h0);

    // Data on the 16th WAIT cycle wins over the timeout.
    do_reset(32'h0);
    rv_withhold = 1'b1;
    rst = 1'b1;
    wait_hs(10, "tl");
    for (int i = 1; i <= 15; i++) cyc();
    auto_mem = 1'b0;
    @(negedge clk);
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = NOP;
    @(negedge clk);
    bus.imem_rvalid = 1'b0;
    #1;
    check("tl_instr_valid", {31'b0, bus.instr_valid}, 32'h1);
    check("tl_instr",       bus.instr, NOP);
    check("tl_no_fault",    {31'b0, bus.fetch_fault}, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that consumes the PC produced by `branch_unit` and closes the loop around it. Reads the instruction at `pc` from instruction memory and presents it to execute/branch logic. Pulses `bcu_enable` once per retired instruction so `branch_unit` advances or redirects the PC, then fetches again from the updated PC. Sits between instruction memory and the `branch_unit`/ALU pair.

## Interface
Parameters:
- `TIMEOUT`, 255 — `WAIT`-state cycle limit before a timeout fault; only used with `FETCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  — single clock; all logic on posedge.
- `rst`  in  1  — synchronous, active-low reset.
- `pc`  in  32 (`register_t`)  — current PC, driven by `branch_unit.pc_out`.
- `bcu_enable`  out  1  — one-cycle pulse; drives `branch_unit.enable`.
- `imem_req`  out  1  — fetch request.
- `imem_addr`  out  32  — fetch address; equals `pc` while `imem_req`=1.
- `imem_gnt`  in  1  — request accepted this cycle.
- `imem_rvalid`  in  1  — read data valid.
- `imem_rdata`  in  32  — instruction word.
- `instr`  out  32 (`instruction_t`)  — captured instruction; drives `branch_unit.instr` and decode.
- `instr_valid`  out  1  — `instr` holds a fetched, not-yet-retired word.
- `exec_ready`  in  1  — downstream ready to retire `instr`.
- `fetch_fault`  out  1  — sticky fault flag.
- `fault_cause`  out  2 (`fault_cause_t`)  — values: `NONE`=0, `MISALIGN`=1, `TIMEOUT`=2.
- `fault_pc`  out  32  — PC at which the fault occurred.
- `instr_count`  out  32  — number of retired instructions.

## Operation
- FSM states (`fetch_state_t`): `FETCH`, `WAIT`, `ISSUE`, `EXEC`, `HALT`.
- `FETCH`:
  - If `pc[1:0]`≠0: no request; set `fetch_fault`=1, `fault_cause`=`MISALIGN`, `fault_pc`=`pc`; go to `HALT`.
  - Otherwise: `imem_req`=1, `imem_addr`=`pc`. Stay in `FETCH` until `imem_gnt`, then go to `WAIT`.
- `WAIT`:
  - On `imem_rvalid`: `instr`←`imem_rdata`, `instr_valid`←1; go to `ISSUE`.
  - `imem_rvalid` in any other state is ignored.
- `ISSUE`:
  - `instr_valid`=1; hold until `exec_ready`=1, then go to `EXEC`.
- `EXEC` (exactly one cycle):
  - `bcu_enable`=1.
  - `instr_count`+1; wraps modulo 2^32 (0xFFFFFFFF→0).
  - `instr_valid` clears at exit.
  - Go to `FETCH`.
- `instr` holds its value until the next capture; it stays stable through `EXEC` because `branch_unit` samples it then.
- `HALT`: terminal; all request/enable outputs are 0. Only `rst` exits.
- `imem_req` and `bcu_enable` are never 1 in the same cycle.

## Timing
- Reset (`rst`=0 at a posedge, from any state including mid-`WAIT`):
  - Next state is `FETCH`.
  - `instr`=0, `instr_valid`=0, `bcu_enable`=0, `fetch_fault`=0, `fault_cause`=`NONE`, `fault_pc`=0, `instr_count`=0.
  - `imem_req` is 0 while `rst`=0.
  - A memory response pending at reset is dropped.
- First `imem_req` is asserted in the first cycle with `rst`=1.
- Outputs are Moore, decoded from the state register, except `imem_addr`, which follows `pc` combinationally in `FETCH`.
- `branch_unit` updates `pc_out` at the posedge ending `EXEC`. The `FETCH` cycle that follows samples the new PC.
- Minimum retire period is 4 cycles: `FETCH` with gnt → `WAIT` with rvalid → `ISSUE` with ready → `EXEC`.
- `imem_rvalid` arriving in the same cycle as `imem_gnt` is not accepted. Memory returns data no earlier than the cycle after the grant.

## Configuration
- `FETCH_TIMEOUT_EN` defined:
  - A counter runs in `WAIT`: cleared on entry, incremented each cycle without `imem_rvalid`.
  - When it reaches `TIMEOUT`: `fetch_fault`=1, `fault_cause`=`TIMEOUT`, `fault_pc`=`pc`; go to `HALT`.
  - `imem_rvalid` in the same cycle as the limit wins: instruction captured, no fault.
- Not defined: `WAIT` waits indefinitely; `TIMEOUT` cause is never produced; the counter is absent.

## Structure
- Add `fetch_state_t` and `fault_cause_t` to package `opcodes`, alongside `instruction_t` and `register_t`.
- One optional sub-module, `fetch_watchdog`: counter plus compare, instantiated only under `FETCH_TIMEOUT_EN`.

## Test plan
- Sequential run: `branch_unit` and memory model both attached; memory returns 32'h00000033 (no-op) with 1-cycle latency; start PC 0x0; 10 instructions → `imem_addr` sequence 0x0,0x4,…,0x24; `instr_count`=10; 4 cycles per retire.
- Jump: word at 0x8 is JAL to 0x00020000 → next `imem_addr`=0x00020000, `ret_addr`=0xC.
- Backpressure and latency:
  - Hold `exec_ready`=0 for 5 cycles → `instr_valid` held, `instr` stable, no `bcu_enable`.
  - Hold `imem_gnt`=0 for 3 cycles → `imem_req` held, `imem_addr` stable.
- Misaligned PC: force `pc`=0x00000102 → no `imem_req`; `fetch_fault`=1, `MISALIGN`, `fault_pc`=0x102; stays in `HALT` for 20 cycles.
- Timeout, with `FETCH_TIMEOUT_EN` and `TIMEOUT`=16:
  - Withhold `imem_rvalid` → `TIMEOUT` fault after 16 `WAIT` cycles.
  - `imem_rvalid` on cycle 16 → normal capture, no fault.
- Reset in `WAIT`, then a late `imem_rvalid` → response ignored; `instr_valid`=0; `instr_count`=0; fresh `imem_req` after `rst` deasserts.
